// File: rtl/alu_bit_serial_seq.sv
// Bit-serial sequencer for a shared 1-bit MIPS-style ALU slice.
// Latches two operands and a 4-bit control word, feeds the slice one bit
// pair per cycle (LSB first), collects the result bits and the carry chain,
// then reports the full-width result with carry, overflow and zero flags.
module alu_bit_serial_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_ainv,
  output logic             slice_binv,
  output logic             slice_cin,
  output logic [1:0]       slice_op,
  input  logic             slice_res,
  input  logic             slice_cout,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Holds the WIDTH-1 most recently produced bits; the final bit comes
  // straight from the slice on the last RUN edge.
  logic [WIDTH-2:0] res_q, res_d;
  logic [3:0]       ctl_q, ctl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             run;
  logic             ctl_legal;
  logic             arith;
  logic [WIDTH-1:0] res_full;

  assign run      = (state_q == RUN);
  assign arith    = (ctl_q[1:0] == 2'b10);
  assign res_full = {slice_res, res_q};

  // Decode the accepted control words: AND, OR, ADD, SUB, NOR.
  always_comb begin
    ctl_legal = 1'b0;
    case (alu_ctl)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100: ctl_legal = 1'b1;
      default:                                     ctl_legal = 1'b0;
    endcase
  end

  // Next-state logic for the FSM, datapath shift registers and flags.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    ctl_d    = ctl_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (ctl_legal) begin
            a_d     = a;
            b_d     = b;
            ctl_d   = alu_ctl;
            cnt_d   = '0;
            // binvert doubles as the initial carry so SUB computes a + ~b + 1.
            carry_d = alu_ctl[2];
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = res_full[WIDTH-1:1];
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          state_d  = FIN;
          result_d = res_full;
          // Overflow is carry into the MSB xor carry out of it.
          cout_d   = arith & slice_cout;
          ovf_d    = arith & (carry_q ^ slice_cout);
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      ctl_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      ctl_q    <= ctl_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // Slice drive is gated so the slice sees all zeros outside RUN.
  always_comb begin
    slice_a    = run & a_q[0];
    slice_b    = run & b_q[0];
    slice_ainv = run & ctl_q[3];
    slice_binv = run & ctl_q[2];
    slice_cin  = run & carry_q;
    slice_op   = run ? ctl_q[1:0] : 2'b00;
  end

  // Status and result outputs.
  always_comb begin
    busy      = run;
    done      = (state_q == FIN);
    err       = err_q;
    result    = result_q;
    carry_out = cout_q;
    overflow  = ovf_q;
    zero      = (result_q == '0);
  end

endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// Bench for alu_bit_serial_seq: models the 1-bit slice, runs a directed
// vector table, random operations against an arithmetic reference, and
// hand sequences for illegal control, ignored start and mid-run reset.
module tb_alu_bit_serial_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   alu_ctl;
  logic [W-1:0] a, b;
  logic         slice_a, slice_b, slice_ainv, slice_binv, slice_cin;
  logic [1:0]   slice_op;
  logic         slice_res, slice_cout;
  logic         busy, done, err;
  logic [W-1:0] result;
  logic         carry_out, overflow, zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_bit_serial_seq #(.WIDTH(W), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .alu_ctl    (alu_ctl),
    .a          (a),
    .b          (b),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_ainv (slice_ainv),
    .slice_binv (slice_binv),
    .slice_cin  (slice_cin),
    .slice_op   (slice_op),
    .slice_res  (slice_res),
    .slice_cout (slice_cout),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .result     (result),
    .carry_out  (carry_out),
    .overflow   (overflow),
    .zero       (zero)
  );

  // Combinational 1-bit MIPS ALU slice.
  logic sa, sb;
  always_comb begin
    sa         = slice_a ^ slice_ainv;
    sb         = slice_b ^ slice_binv;
    slice_res  = 1'b0;
    case (slice_op)
      2'b00:   slice_res = sa & sb;
      2'b01:   slice_res = sa | sb;
      2'b10:   slice_res = sa ^ sb ^ slice_cin;
      default: slice_res = 1'b0;
    endcase
    slice_cout = (sa & sb) | (sa & slice_cin) | (sb & slice_cin);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Word-level reference: plain arithmetic on the whole operands.
  task automatic ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic [3:0] ctl,
                        output logic [W-1:0] r, output logic c, output logic v, output logic z);
    logic [W:0] s;
    s = '0;
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (ctl)
      4'b0000: r = ra & rb;
      4'b0001: r = ra | rb;
      4'b1100: r = ~(ra | rb);
      4'b0010: begin
        s = {1'b0, ra} + {1'b0, rb};
        r = s[W-1:0];
        c = s[W];
        v = (ra[W-1] == rb[W-1]) && (r[W-1] != ra[W-1]);
      end
      4'b0110: begin
        s = {1'b0, ra} + {1'b0, ~rb} + 1;
        r = s[W-1:0];
        c = s[W];
        v = (ra[W-1] != rb[W-1]) && (r[W-1] != ra[W-1]);
      end
      default: r = '0;
    endcase
    z = (r == '0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_zero"}, zero, 1);
    check({tag, "_cout"}, carry_out, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_slice"}, {slice_a, slice_b, slice_ainv, slice_binv, slice_cin, slice_op}, 0);
  endtask

  // Issue one operation and wait for done. If inject_at > 0, a junk start
  // with different operands is pulsed during that busy cycle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [3:0] tctl,
                        input int inject_at, output logic [W-1:0] r, output logic c,
                        output logic v, output logic z, output int lat, output int bcnt);
    bit got;
    @(negedge clk);
    a       = ta;
    b       = tb_v;
    alu_ctl = tctl;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got   = 0;
    lat   = 0;
    bcnt  = 0;
    r = '0; c = 0; v = 0; z = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      if (i > 1) @(negedge clk);
      if (inject_at > 0 && i == inject_at) begin
        start   = 1'b1;
        a       = ~ta;
        b       = ~tb_v;
        alu_ctl = 4'b0001;
      end else begin
        start = 1'b0;
      end
      if (i == 1) begin
        check("slice_a0", slice_a, ta[0]);
        check("slice_b0", slice_b, tb_v[0]);
        check("slice_ctl", {slice_ainv, slice_binv, slice_op}, tctl);
        check("slice_cin0", slice_cin, tctl[2]);
      end
      if (busy) bcnt++;
      if (done) begin
        got = 1;
        lat = i;
        r   = result;
        c   = carry_out;
        v   = overflow;
        z   = zero;
      end
    end
    start = 1'b0;
    if (!got) check("done_timeout", 0, 1);
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [3:0]   ctl;
    logic [W-1:0] er;
    logic         ec;
    logic         ev;
    logic         ez;
  } vec_t;

  vec_t vecs[8];
  logic [3:0] legal_ctl[5];

  initial begin
    logic [W-1:0] r, er, last_r, ra, rb;
    logic c, v, z, ec, ev, ez;
    logic [3:0] ctl;
    int lat, bcnt, done_seen;

    vecs[0] = '{8'h3C, 8'h05, 4'b0010, 8'h41, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 4'b0010, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h01, 4'b0010, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h05, 4'b0110, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h01, 4'b0110, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'hCA, 8'h0F, 4'b0000, 8'h0A, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'hCA, 8'h0F, 4'b0001, 8'hCF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'hCA, 8'h0F, 4'b1100, 8'h30, 1'b0, 1'b0, 1'b0};
    legal_ctl = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100};

    rst = 1'b1; start = 1'b0; alu_ctl = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");

    // Directed table.
    last_r = '0;
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].ctl, 0, r, c, v, z, lat, bcnt);
      check($sformatf("vec%0d_result", i), r, vecs[i].er);
      check($sformatf("vec%0d_cout", i), c, vecs[i].ec);
      check($sformatf("vec%0d_ovf", i), v, vecs[i].ev);
      check($sformatf("vec%0d_zero", i), z, vecs[i].ez);
      check($sformatf("vec%0d_latency", i), lat, W + 1);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, W);
      last_r = vecs[i].er;
    end
    @(negedge clk);
    check("idle_slice", {slice_a, slice_b, slice_ainv, slice_binv, slice_cin, slice_op}, 0);

    // Illegal control word: err pulse next cycle only, no state change.
    a = 8'h11; b = 8'h22; alu_ctl = 4'b0011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("illegal_err", err, 1);
    check("illegal_busy", busy, 0);
    @(negedge clk);
    check("illegal_err_clear", err, 0);
    check("illegal_busy2", busy, 0);
    check("illegal_result", result, last_r);

    // Start pulsed mid-run with new operands: ignored, not queued.
    run_op(8'h3C, 8'h05, 4'b0010, 3, r, c, v, z, lat, bcnt);
    check("midstart_result", r, 8'h41);
    check("midstart_latency", lat, W + 1);
    @(negedge clk);
    check("midstart_not_queued", busy, 0);
    @(negedge clk);
    check("midstart_not_queued2", busy, 0);

    // Reset four cycles into an ADD.
    @(negedge clk);
    a = 8'h7F; b = 8'h01; alu_ctl = 4'b0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("midrst");
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    run_op(8'h12, 8'h34, 4'b0010, 0, r, c, v, z, lat, bcnt);
    check("post_rst_result", r, 8'h46);
    check("post_rst_latency", lat, W + 1);

    // Random operations against the word-level reference.
    for (int i = 0; i < 40; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      ctl = legal_ctl[$urandom_range(0, 4)];
      ref_op(ra, rb, ctl, er, ec, ev, ez);
      run_op(ra, rb, ctl, 0, r, c, v, z, lat, bcnt);
      check($sformatf("rnd%0d_result", i), r, er);
      check($sformatf("rnd%0d_flags", i), {c, v, z}, {ec, ev, ez});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
